// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and mode constants for the ProgramCounter sequencer.
package pc_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_RUN    = 3'd2,
        S_JUMP   = 3'd3,
        S_DONE   = 3'd4,
        S_PAUSED = 3'd5
    } state_t;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_REPEAT  = 1'b1;
endpackage

// File: rtl/pc_seq_tick_gate.sv
// pc_seq_tick_gate: qualifies tick against an outstanding PC command (and pause when PC_SEQ_PAUSE_EN).
module pc_seq_tick_gate (
    input  logic tick,
    input  logic pend,
`ifdef PC_SEQ_PAUSE_EN
    input  logic pause,
`endif
    output logic tick_ok
);
`ifdef PC_SEQ_PAUSE_EN
    assign tick_ok = tick & ~pend & ~pause;
`else
    assign tick_ok = tick & ~pend;
`endif
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: drives ProgramCounter reset/load/inc from start/stop/tick/jump requests.
// Optional pause input and PAUSED state are enabled by defining PC_SEQ_PAUSE_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             tick,
`ifdef PC_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             jump_req,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic [WIDTH-1:0] pc_value,
    output logic             pc_reset,
    output logic             pc_load,
    output logic             pc_inc,
    output logic [WIDTH-1:0] pc_reset_val,
    output logic [WIDTH-1:0] pc_load_val,
    output logic             busy,
    output logic             done,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] START_V = WIDTH'(START_ADDR);
    localparam logic [WIDTH-1:0] END_V   = WIDTH'(END_ADDR);

    state_t state;
    logic   mode_q;
    logic   tick_ok;

    assign pc_reset_val = START_V;

    // pc_value is stale for one cycle after an inc/load pulse, so ticks then are dropped
    pc_seq_tick_gate u_gate (
        .tick    (tick),
        .pend    (pc_inc | pc_load),
`ifdef PC_SEQ_PAUSE_EN
        .pause   (pause),
`endif
        .tick_ok (tick_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            mode_q      <= MODE_ONESHOT;
            pc_reset    <= 1'b0;
            pc_load     <= 1'b0;
            pc_inc      <= 1'b0;
            wrap        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pc_load_val <= START_V;
        end else begin
            pc_reset <= 1'b0;
            pc_load  <= 1'b0;
            pc_inc   <= 1'b0;
            wrap     <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_INIT;
                        pc_reset <= 1'b1;
                        mode_q   <= mode;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                S_INIT, S_JUMP: begin
                    state <= stop ? S_IDLE : S_RUN;
                    busy  <= ~stop;
                end
                S_RUN: begin
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
`ifdef PC_SEQ_PAUSE_EN
                    end else if (pause) begin
                        state <= S_PAUSED;
`endif
                    end else if (jump_req) begin
                        state       <= S_JUMP;
                        pc_load     <= 1'b1;
                        pc_load_val <= jump_addr;
                    end else if (tick_ok) begin
                        if (pc_value != END_V) begin
                            pc_inc <= 1'b1;
                        end else if (mode_q == MODE_REPEAT) begin
                            pc_load     <= 1'b1;
                            pc_load_val <= START_V;
                            wrap        <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
`ifdef PC_SEQ_PAUSE_EN
                S_PAUSED: begin
                    state <= stop ? S_IDLE : (pause ? S_PAUSED : S_RUN);
                    busy  <= ~stop;
                end
`endif
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer driving a behavioural ProgramCounter (START=0, END=5).
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       reset, start, stop, mode, tick, jump_req;
    logic [7:0] jump_addr, pc_q;
    logic       pc_reset, pc_load, pc_inc, busy, done, wrap;
    logic [7:0] pc_reset_val, pc_load_val;
`ifdef PC_SEQ_PAUSE_EN
    logic       pause;
`endif
    int vectors = 0;
    int errs = 0;
    logic obs_inc, obs_load, obs_wrap;

    always #5 clk = ~clk;

    // ProgramCounter model: applies the command on the edge after the pulse
    always_ff @(posedge clk) begin
        if (pc_reset) pc_q <= pc_reset_val;
        else if (pc_load) pc_q <= pc_load_val;
        else if (pc_inc) pc_q <= pc_q + 8'd1;
    end

    pc_sequencer #(.WIDTH(8), .START_ADDR(0), .END_ADDR(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .tick         (tick),
`ifdef PC_SEQ_PAUSE_EN
        .pause        (pause),
`endif
        .jump_req     (jump_req),
        .jump_addr    (jump_addr),
        .pc_value     (pc_q),
        .pc_reset     (pc_reset),
        .pc_load      (pc_load),
        .pc_inc       (pc_inc),
        .pc_reset_val (pc_reset_val),
        .pc_load_val  (pc_load_val),
        .busy         (busy),
        .done         (done),
        .wrap         (wrap)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        cyc();
        obs_inc  = pc_inc;
        obs_load = pc_load;
        obs_wrap = wrap;
        tick = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic do_start(input logic m);
        mode  = m;
        start = 1'b1;
        cyc();
        vectors++;
        if ({pc_reset, busy, done} !== 3'b110) begin
            $display("FAIL start_pulse: {pc_reset,busy,done}=%b expected 110", {pc_reset, busy, done});
            errs++;
        end
        start = 1'b0;
        cyc();
        cyc();
        vectors++;
        if (pc_q !== 8'd0) begin
            $display("FAIL start_pc: pc=%0d expected 0", pc_q);
            errs++;
        end
    endtask

    task automatic do_jump(input logic [7:0] a);
        jump_req  = 1'b1;
        jump_addr = a;
        cyc();
        jump_req = 1'b0;
        cyc();
        cyc();
        vectors++;
        if (pc_q !== a) begin
            $display("FAIL jump_pc: pc=%0d expected %0d", pc_q, a);
            errs++;
        end
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        vectors++;
        if ({pc_reset, pc_load, pc_inc, wrap, busy, done} !== 6'b0) begin
            $display("FAIL reset_ctl: outputs=%b expected 000000", {pc_reset, pc_load, pc_inc, wrap, busy, done});
            errs++;
        end
        vectors++;
        if (pc_load_val !== 8'd0 || pc_reset_val !== 8'd0) begin
            $display("FAIL reset_vals: load_val=%0d reset_val=%0d expected 0 0", pc_load_val, pc_reset_val);
            errs++;
        end
    endtask

    task automatic test_oneshot();
        do_start(1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick_pulse();
            vectors++;
            if (pc_q !== 8'(k) || obs_inc !== 1'b1) begin
                $display("FAIL oneshot_count: pc=%0d inc=%b expected %0d 1", pc_q, obs_inc, k);
                errs++;
            end
        end
        tick_pulse();
        vectors++;
        if ({done, busy, obs_inc, obs_load} !== 4'b1000 || pc_q !== 8'd5) begin
            $display("FAIL oneshot_done: done,busy,inc,load=%b pc=%0d expected 1000 5", {done, busy, obs_inc, obs_load}, pc_q);
            errs++;
        end
    endtask

    task automatic test_repeat();
        logic [7:0] exp_seq [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
        int wraps = 0;
        do_start(1'b1);
        for (int k = 0; k < 7; k++) begin
            tick_pulse();
            wraps += int'(obs_wrap);
            vectors++;
            if (pc_q !== exp_seq[k] || done !== 1'b0) begin
                $display("FAIL repeat_seq[%0d]: pc=%0d done=%b expected %0d 0", k, pc_q, done, exp_seq[k]);
                errs++;
            end
            if (k == 1) begin
                mode  = 1'b0;
                start = 1'b1;
                cyc();
                start = 1'b0;
                vectors++;
                if (pc_reset !== 1'b0) begin
                    $display("FAIL start_while_busy: pc_reset=%b expected 0", pc_reset);
                    errs++;
                end
                cyc();
            end
        end
        vectors++;
        if (wraps !== 1 || busy !== 1'b1) begin
            $display("FAIL repeat_wrap: wraps=%0d busy=%b expected 1 1", wraps, busy);
            errs++;
        end
        do_stop();
    endtask

    task automatic test_jump();
        do_start(1'b0);
        tick_pulse();
        jump_req  = 1'b1;
        jump_addr = 8'd3;
        tick      = 1'b1;
        cyc();
        jump_req = 1'b0;
        tick     = 1'b0;
        vectors++;
        if ({pc_load, pc_inc} !== 2'b10 || pc_load_val !== 8'd3) begin
            $display("FAIL jump_cmd: load,inc=%b load_val=%0d expected 10 3", {pc_load, pc_inc}, pc_load_val);
            errs++;
        end
        cyc();
        cyc();
        vectors++;
        if (pc_q !== 8'd3) begin
            $display("FAIL jump_target: pc=%0d expected 3", pc_q);
            errs++;
        end
        tick_pulse();
        tick_pulse();
        tick_pulse();
        vectors++;
        if (pc_q !== 8'd5 || done !== 1'b1) begin
            $display("FAIL jump_done: pc=%0d done=%b expected 5 1", pc_q, done);
            errs++;
        end
    endtask

    task automatic test_jump_bounds();
        do_start(1'b1);
        do_jump(8'd5);
        tick_pulse();
        vectors++;
        if (pc_q !== 8'd0 || obs_wrap !== 1'b1) begin
            $display("FAIL jump_end_reload: pc=%0d wrap=%b expected 0 1", pc_q, obs_wrap);
            errs++;
        end
        do_jump(8'd254);
        tick_pulse();
        tick_pulse();
        vectors++;
        if (pc_q !== 8'd0 || obs_wrap !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL jump_past_end: pc=%0d wrap=%b busy=%b expected 0 0 1", pc_q, obs_wrap, busy);
            errs++;
        end
        do_stop();
    endtask

    task automatic test_stop();
        do_start(1'b0);
        tick_pulse();
        tick_pulse();
        stop = 1'b1;
        tick = 1'b1;
        cyc();
        stop = 1'b0;
        tick = 1'b0;
        vectors++;
        if ({busy, pc_inc, pc_load, done} !== 4'b0000) begin
            $display("FAIL stop_ctl: busy,inc,load,done=%b expected 0000", {busy, pc_inc, pc_load, done});
            errs++;
        end
        cyc();
        cyc();
        vectors++;
        if (pc_q !== 8'd2) begin
            $display("FAIL stop_hold: pc=%0d expected 2", pc_q);
            errs++;
        end
        do_start(1'b0);
    endtask

    task automatic test_reset_and_drop();
        for (int k = 0; k < 4; k++) tick_pulse();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        vectors++;
        if ({pc_reset, pc_load, pc_inc, wrap, busy, done} !== 6'b0) begin
            $display("FAIL midrun_reset: outputs=%b expected 000000", {pc_reset, pc_load, pc_inc, wrap, busy, done});
            errs++;
        end
        cyc();
        vectors++;
        if (pc_q !== 8'd4) begin
            $display("FAIL midrun_pc: pc=%0d expected 4", pc_q);
            errs++;
        end
        do_start(1'b0);
        tick = 1'b1;
        cyc();
        cyc();
        tick = 1'b0;
        cyc();
        cyc();
        vectors++;
        if (pc_q !== 8'd1) begin
            $display("FAIL tick_drop: pc=%0d expected 1", pc_q);
            errs++;
        end
        do_stop();
    endtask

`ifdef PC_SEQ_PAUSE_EN
    task automatic test_pause();
        do_start(1'b0);
        tick_pulse();
        tick_pulse();
        pause = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) tick_pulse();
        vectors++;
        if (pc_q !== 8'd2 || busy !== 1'b1) begin
            $display("FAIL pause_hold: pc=%0d busy=%b expected 2 1", pc_q, busy);
            errs++;
        end
        pause = 1'b0;
        cyc();
        for (int k = 3; k <= 5; k++) begin
            tick_pulse();
            vectors++;
            if (pc_q !== 8'(k)) begin
                $display("FAIL pause_resume: pc=%0d expected %0d", pc_q, k);
                errs++;
            end
        end
        do_stop();
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; tick = 1'b0;
        jump_req = 1'b0; jump_addr = 8'd0;
`ifdef PC_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        test_reset();
        test_oneshot();
        test_repeat();
        test_jump();
        test_jump_bounds();
        test_stop();
        test_reset_and_drop();
`ifdef PC_SEQ_PAUSE_EN
        test_pause();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
